// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Produces enable and
//   bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves data
//   memory wait states, taken-branch squash, load-use hazards and HI/LO
//   hazards against a background mult/div unit whose latency is tracked here.
//   It also flags memory timeouts and counts stalled cycles.
//
// Ports
//   clk, Reset            clock; synchronous active-low reset
//   id_rs/id_rt           source fields of the ID instruction
//   id_uses_rs/id_uses_rt ID instruction reads rs / rt
//   ex_memread, ex_rt     load in EX and its destination register
//   id_md_start/_is_div   ID instruction starts mult (0) or div (1)
//   id_md_read            ID instruction accesses HI/LO
//   ex_branch_taken       branch/jump in EX resolved taken
//   mem_req, mem_ready    MEM-stage access request and completion
//   *_en, *_flush         pipeline register enables and bubble inserts
//   md_busy, md_done      mult/div in flight; one-cycle completion pulse
//   mem_err               sticky memory-timeout flag
//   stall_cnt             saturating count of cycles with PC held
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter int unsigned DIV_CYCLES  = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rt,
  input  logic        id_md_start,
  input  logic        id_md_is_div,
  input  logic        id_md_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES);
  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  // One pipeline action per cycle, in priority order.
  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_MEM_WAIT,
    ACT_SQUASH,
    ACT_HOLD_ID
  } action_t;

  action_t    action;
  logic [5:0] md_cnt;
  logic [7:0] wait_cnt;
  logic       mem_stall;
  logic       load_use;
  logic       md_hazard;
  logic       md_issue;

  assign md_busy   = (md_cnt != '0);
  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = ex_memread & (ex_rt != '0) &
                     ((id_uses_rs & (id_rs == ex_rt)) |
                      (id_uses_rt & (id_rt == ex_rt)));
  assign md_hazard = md_busy & (id_md_read | id_md_start);

  always_comb begin
    if (mem_stall)                  action = ACT_MEM_WAIT;
    else if (ex_branch_taken)       action = ACT_SQUASH;
    else if (load_use || md_hazard) action = ACT_HOLD_ID;
    else                            action = ACT_NONE;
  end

  // A start that is squashed, held or blocked by a busy unit never issues.
  assign md_issue = id_md_start & (action == ACT_NONE);

  always_comb begin
    pc_en       = Reset;
    ifid_en     = Reset;
    idex_en     = Reset;
    exmem_en    = Reset;
    memwb_en    = Reset;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (Reset) begin
      case (action)
        ACT_MEM_WAIT: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          memwb_flush = 1'b1;
        end
        ACT_SQUASH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        ACT_HOLD_ID: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      md_cnt    <= '0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      md_done   <= 1'b0;
    end else begin
      md_done <= (md_cnt == 6'd1);

      if (md_issue)
        md_cnt <= id_md_is_div ? DIV_LOAD : MUL_LOAD;
      else if (md_busy)
        md_cnt <= md_cnt - 6'd1;

      // Timeout compares the pre-increment count, so mem_err rises on
      // the (MEM_TIMEOUT+1)-th consecutive stalled edge.
      if (mem_stall) begin
        if (wait_cnt != '1)
          wait_cnt <= wait_cnt + 8'd1;
        if (wait_cnt == TIMEOUT)
          mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (MEM_TIMEOUT overridden to 3).
module tb_pipe_hazard_ctrl;

  localparam int unsigned TB_TIMEOUT = 3;

  logic        clk;
  logic        Reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_memread;
  logic        id_md_start, id_md_is_div, id_md_read;
  logic        ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, memwb_en, memwb_flush;
  logic        md_busy, md_done, mem_err;
  logic [15:0] stall_cnt;

  pipe_hazard_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32),
    .MEM_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk            (clk),
    .Reset          (Reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_memread     (ex_memread),
    .ex_rt          (ex_rt),
    .id_md_start    (id_md_start),
    .id_md_is_div   (id_md_is_div),
    .id_md_read     (id_md_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_en        (idex_en),
    .idex_flush     (idex_flush),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .memwb_flush    (memwb_flush),
    .md_busy        (md_busy),
    .md_done        (md_done),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt)
  );

  // Starts high so each cycle's negedge (sample) precedes its posedge.
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ctrl bit order: pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem, memwb_en, memwb_flush
  typedef struct {
    logic [7:0]  ctrl;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] sc;
    logic        issue;
    logic        ms;
  } exp_t;

  exp_t exp_q[$];

  int m_md, m_wait, m_stall;
  bit m_err, m_done;

  function automatic exp_t model_out();
    exp_t e;
    logic ms, lu, mh, busy;
    busy = (m_md != 0);
    ms   = mem_req && !mem_ready;
    lu   = ex_memread && (ex_rt != 0) &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    mh   = busy && (id_md_read || id_md_start);
    if (!Reset)               e.ctrl = 8'b0000_0000;
    else if (ms)              e.ctrl = 8'b0000_0011;
    else if (ex_branch_taken) e.ctrl = 8'b1111_1110;
    else if (lu || mh)        e.ctrl = 8'b0001_1110;
    else                      e.ctrl = 8'b1101_0110;
    e.busy  = busy;
    e.done  = m_done;
    e.err   = m_err;
    e.sc    = 16'(m_stall);
    e.ms    = ms;
    e.issue = Reset && id_md_start && !ms && !ex_branch_taken && !lu && !mh;
    return e;
  endfunction

  task automatic model_edge(input exp_t e);
    if (!Reset) begin
      m_md = 0; m_wait = 0; m_err = 0; m_stall = 0; m_done = 0;
    end else begin
      m_done = (m_md == 1);
      if (e.issue)        m_md = id_md_is_div ? 32 : 4;
      else if (m_md != 0) m_md = m_md - 1;
      if (e.ms) begin
        if (m_wait == int'(TB_TIMEOUT)) m_err = 1;
        if (m_wait < 255) m_wait = m_wait + 1;
      end else begin
        m_wait = 0;
      end
      if (!e.ctrl[7] && m_stall < 65535) m_stall = m_stall + 1;
    end
  endtask

  // Inputs are stable from posedge+1; expected values are queued then.
  task automatic step();
    exp_t e;
    e = model_out();
    exp_q.push_back(e);
    @(posedge clk);
    model_edge(e);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl", {24'd0, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, memwb_en, memwb_flush}, {24'd0, e.ctrl});
      check("md_busy", {31'd0, md_busy}, {31'd0, e.busy});
      check("md_done", {31'd0, md_done}, {31'd0, e.done});
      check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
      check("stall_cnt", {16'd0, stall_cnt}, {16'd0, e.sc});
    end
  end

  task automatic set_idle();
    Reset = 1; id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0;
    id_md_start = 0; id_md_is_div = 0; id_md_read = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic set_load_use(input logic [4:0] rt);
    set_idle();
    ex_memread = 1; ex_rt = rt; id_uses_rs = 1; id_rs = rt;
  endtask

  initial begin
    set_idle();
    Reset = 0;
    m_md = 0; m_wait = 0; m_err = 0; m_stall = 0; m_done = 0;
    @(posedge clk); #1;

    // Reset state: all controls low while Reset is asserted
    Reset = 0; step();
    set_idle(); step();
    check("sc_after_reset", {16'd0, stall_cnt}, 32'd0);

    // Load-use hazards
    set_load_use(5'd5); step();
    check("lu_rs_sc", {16'd0, stall_cnt}, 32'd1);
    set_load_use(5'd0); step();
    check("lu_r0_sc", {16'd0, stall_cnt}, 32'd1);
    set_idle(); ex_memread = 1; ex_rt = 7; id_uses_rt = 1; id_rt = 7; step();
    check("lu_rt_sc", {16'd0, stall_cnt}, 32'd2);
    set_idle(); ex_memread = 1; ex_rt = 9; id_uses_rs = 0; id_rs = 9; step();
    check("lu_unused_sc", {16'd0, stall_cnt}, 32'd2);

    // Branch beats load-use
    set_load_use(5'd5); ex_branch_taken = 1; step();
    check("br_lu_sc", {16'd0, stall_cnt}, 32'd2);

    // Mult latency with HI/LO reads while busy
    set_idle(); id_md_start = 1; id_md_is_div = 0; step();
    check("mul_busy", {31'd0, md_busy}, 32'd1);
    set_idle(); id_md_read = 1;
    for (int unsigned c = 1; c <= 4; c++) step();
    check("mul_done", {31'd0, md_done}, 32'd1);
    check("mul_idle", {31'd0, md_busy}, 32'd0);
    check("mul_sc", {16'd0, stall_cnt}, 32'd6);
    step();
    check("mul_read_free_sc", {16'd0, stall_cnt}, 32'd6);

    // wait_cnt clears between bursts; then timeout after 4th stalled edge
    set_idle(); mem_req = 1; mem_ready = 0;
    for (int unsigned c = 0; c < 3; c++) step();
    set_idle(); mem_req = 1; mem_ready = 1; step();
    check("burst_no_err", {31'd0, mem_err}, 32'd0);
    check("burst_sc", {16'd0, stall_cnt}, 32'd9);
    set_idle(); mem_req = 1; mem_ready = 0;
    for (int unsigned c = 1; c <= 5; c++) begin
      step();
      check("timeout_err", {31'd0, mem_err}, {31'd0, c >= 4});
    end
    set_idle(); mem_req = 1; step();
    check("timeout_sticky", {31'd0, mem_err}, 32'd1);
    check("timeout_sc", {16'd0, stall_cnt}, 32'd14);

    // Div under mem stall, branch and blocked start; done 33 cycles on
    set_idle(); id_md_start = 1; id_md_is_div = 1; step();
    for (int unsigned c = 1; c <= 32; c++) begin
      set_idle();
      if (c >= 3 && c <= 12) begin mem_req = 1; mem_ready = 0; end
      if (c == 20) ex_branch_taken = 1;
      if (c == 25) id_md_start = 1;
      step();
      if (c == 31) check("div_not_done", {31'd0, md_done}, 32'd0);
    end
    check("div_done", {31'd0, md_done}, 32'd1);
    // Issue in the md_done cycle is accepted
    set_idle(); id_md_start = 1; step();
    check("reissue_busy", {31'd0, md_busy}, 32'd1);
    set_idle();
    for (int unsigned c = 0; c < 6; c++) step();

    // Reset in the middle of a div
    set_idle(); id_md_start = 1; id_md_is_div = 1; step();
    set_idle();
    for (int unsigned c = 0; c < 12; c++) step();
    Reset = 0; step();
    set_idle();
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_sc", {16'd0, stall_cnt}, 32'd0);
    check("rst_err", {31'd0, mem_err}, 32'd0);
    check("rst_done", {31'd0, md_done}, 32'd0);
    for (int unsigned c = 0; c < 40; c++) step();

    // Random mix
    for (int unsigned c = 0; c < 600; c++) begin
      Reset           = ($urandom_range(0, 59) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_memread      = ($urandom_range(0, 2) == 0);
      id_md_start     = ($urandom_range(0, 5) == 0);
      id_md_is_div    = 1'($urandom_range(0, 1));
      id_md_read      = ($urandom_range(0, 3) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 3) != 0);
      step();
    end

    // Long stall: wait_cnt and stall_cnt saturation
    set_idle(); Reset = 0; step();
    set_idle(); mem_req = 1; mem_ready = 0;
    for (int unsigned c = 0; c < 65540; c++) step();
    check("sat_sc", {16'd0, stall_cnt}, 32'h0000_FFFF);
    check("sat_err", {31'd0, mem_err}, 32'd1);
    set_load_use(5'd3); step();
    check("sat_hold_sc", {16'd0, stall_cnt}, 32'h0000_FFFF);
    set_idle(); step();

    for (int unsigned c = 0; c < 4 && exp_q.size() > 0; c++) @(negedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
